systolic_result_serializer: RTL
===============================

Name: systolic_result_serializer

Overview:
- Consumer of the systolic array top-level result interface.
- On each result-valid pulse, captures the full N×N signed 8-bit result matrix into a local buffer.
- Streams the buffered elements out one per beat, row-major, over a valid/ready handshake with a last flag.
- Sits between the matrix-multiply top level and downstream byte-wide logic (classifier stage / output FIFO).

Parameters:
- N, 4, matrix dimension; legal range 2..16.
- ELEM_W, 8, signed element width in bits.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_arst_n  input  1  asynchronous active-low reset.
- i_c  input  [N-1:0][N-1:0][ELEM_W-1:0]  signed result matrix; sampled only on a capture cycle.
- i_validResult  input  1  single-cycle pulse; i_c is valid in this cycle.
- o_idle  output  1  high when no matrix is buffered or streaming.
- o_data  output  ELEM_W  current element, signed.
- o_row  output  $clog2(N)  row index of o_data.
- o_col  output  $clog2(N)  column index of o_data.
- o_valid  output  1  o_data is valid.
- i_ready  input  1  downstream accepts the beat.
- o_last  output  1  high with the beat carrying element [N-1][N-1].
- o_overrun  output  1  sticky: a result arrived while busy and was dropped.
- i_clearOverrun  input  1  clears o_overrun.

Behaviour:
- Reset (i_arst_n low, asynchronous): state IDLE. o_valid=0, o_last=0, o_data=0, o_row=0, o_col=0, o_overrun=0, o_idle=1. Buffer contents are don't-care.
- States: IDLE, STREAM.
- IDLE + i_validResult at edge T:
  - Copy i_c into the buffer.
  - Element counter k=0; state STREAM.
  - At T+1: o_valid=1, o_data=buf[0][0], o_row=0, o_col=0.
  - Capture-to-first-beat latency is 1 cycle.
- STREAM, beat transfer: a beat transfers when o_valid && i_ready. On transfer, k increments and outputs present buf[k/N][k%N] in the next cycle.
- Back-pressure: o_data, o_row, o_col and o_last hold stable while o_valid && !i_ready.
- Last beat: o_last = (k == N*N-1) && o_valid. On its transfer:
  - If i_validResult is high in the same cycle: capture the new matrix, k=0, remain STREAM. o_valid stays high with no bubble.
  - Otherwise: state IDLE, o_valid=0, o_last=0.
- Overrun: i_validResult in STREAM, other than on the last-beat transfer cycle:
  - The new matrix is dropped.
  - The buffer and stream are unaffected.
  - o_overrun is set the next cycle and stays set until i_clearOverrun.
  - If set and clear occur in the same cycle, set wins.
- o_idle = (state == IDLE), registered-state-derived with no combinational path from inputs.
- Width rules: counter width is $clog2(N*N). No arithmetic on data; elements pass through bit-exact.
- i_ready low for any duration causes no data loss and no timeout.
- Reset mid-stream: immediately return to reset values; the partially streamed matrix is discarded.
- No combinational path from i_ready to o_valid.

Decomposition:
- Shared package systolic_pkg holds:
  - ELEM_W default constant.
  - Element typedef: signed logic [ELEM_W-1:0].
  - State enum: IDLE, STREAM.
- Single module. The buffer is a flat register array indexed by k; no sub-module is warranted.

Test Plan:
- Basic: N=4, reset, pulse i_validResult with i_c[r][c]=r*4+c, i_ready=1.
  - o_valid rises the cycle after the pulse.
  - 16 consecutive beats with data 0..15 and row/col matching.
  - o_last only on data 15; o_valid=0 and o_idle=1 the cycle after.
- Back-pressure: same stimulus, i_ready toggling 1,0,0,1,…
  - Every element is delivered exactly once in order.
  - o_data is stable across every stall cycle.
- Back-to-back: second pulse (i_c=-1 everywhere, i.e. 8'hFF) coincident with the last-beat transfer.
  - Beat 17 is 8'hFF at [0][0] with no gap in o_valid.
  - o_overrun stays 0.
- Overrun: second pulse at beat 5 of 16.
  - Stream still outputs the original 0..15.
  - o_overrun=1 from the next cycle.
  - i_clearOverrun pulse clears it; set and clear in the same cycle leave it 1.
- Reset mid-stream: assert i_arst_n=0 asynchronously after beat 7.
  - o_valid and o_overrun drop immediately.
  - o_idle=1.
  - A new pulse after release streams from [0][0].
- Signed pass-through, N=2: i_c = {-128, 127, -1, 0}.
  - Beats are exactly 8'h80, 8'h7F, 8'hFF, 8'h00.
  - o_last on the 4th beat.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared element type, default width and serializer states.
package systolic_pkg;
  localparam int ELEM_W_DEF = 8;
  typedef logic signed [ELEM_W_DEF-1:0] elem_t;
  typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/systolic_result_serializer.sv
// systolic_result_serializer: buffers an NxN result matrix and streams it row-major over valid/ready.
module systolic_result_serializer
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic                              i_clk,
  input  logic                              i_arst_n,
  input  logic [N-1:0][N-1:0][ELEM_W-1:0]   i_c,
  input  logic                              i_validResult,
  output logic                              o_idle,
  output logic signed [ELEM_W-1:0]          o_data,
  output logic [$clog2(N)-1:0]              o_row,
  output logic [$clog2(N)-1:0]              o_col,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic                              o_last,
  output logic                              o_overrun,
  input  logic                              i_clearOverrun
);
  localparam int KW = $clog2(N*N);
  localparam int RW = $clog2(N);
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [RW-1:0] row_q, row_d, col_q, col_d;
  logic ovr_q, ovr_d;
  logic [N*N-1:0][ELEM_W-1:0] mem_q;
  logic xfer, last, capture, col_wrap;
  // row/col are tracked alongside k so no divider is needed for the indices
  always_comb begin
    xfer     = (state_q == STREAM) && i_ready;
    last     = k_q == KW'(N*N-1);
    col_wrap = col_q == RW'(N-1);
    capture  = i_validResult && (state_q == IDLE || (xfer && last));
    state_d  = capture ? STREAM : (xfer && last) ? IDLE : state_q;
    k_d      = capture ? '0 : xfer ? k_q + KW'(1) : k_q;
    col_d    = (capture || (xfer && col_wrap)) ? '0 : xfer ? col_q + RW'(1) : col_q;
    row_d    = capture ? '0 : (xfer && col_wrap) ? row_q + RW'(1) : row_q;
    ovr_d    = (i_validResult && state_q == STREAM && !(xfer && last)) || (ovr_q && !i_clearOverrun);
  end
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ovr_q   <= ovr_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (capture) mem_q <= i_c;
  end
  assign o_valid   = state_q == STREAM;
  assign o_idle    = state_q == IDLE;
  assign o_last    = o_valid && last;
  assign o_data    = o_valid ? mem_q[k_q] : '0;
  assign o_row     = o_valid ? row_q : '0;
  assign o_col     = o_valid ? col_q : '0;
  assign o_overrun = ovr_q;
endmodule
